uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
Serial UART transmitter, the transmit-side companion of uart_rx on the CORDIC-UART link. It accepts one data word per valid/ready handshake and serialises it LSB-first as a frame: start bit, data bits, optional parity bit, stop bit(s). Its bit period is derived exactly as uart_rx derives its sampling period, so a loopback between the two has zero baud mismatch.

Parameters:
CLK_FREQ_MHZ, 100_000_000, system clock frequency in Hz (name kept consistent with uart_rx)
BAUD_RATE, 3_000_000, nominal baud rate
OVERSAMPLE_RATE, 16, oversample factor used only to derive the bit period
NUM_DATA_BITS, 8, data bits per frame, 5 to 9
PARITY_ON, 1, 0 = no parity bit, 1 = parity bit sent
PARITY_EO, 1, 0 = even parity, 1 = odd parity
NUM_STOP_BITS, 1, stop bits per frame, 1 or 2

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous, active-high reset
i_tx_byte  in  NUM_DATA_BITS  word to send
i_tx_byte_valid  in  1  word available
o_tx_ready  out  1  transmitter can accept a word
o_tx  out  1  serial line, idle high
o_tx_busy  out  1  frame in progress

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Bit period: BIT_CLKS = OVERSAMPLE_RATE * int'(CLK_FREQ_MHZ / (BAUD_RATE * OVERSAMPLE_RATE)). With the defaults this is 16 * 2 = 32 clocks.
- Reset values (all outputs registered): o_tx = 1, o_tx_ready = 0, o_tx_busy = 0, state = IDLE, all counters = 0.
- o_tx_ready rises on the first clock after i_rst deasserts.
- Handshake: the word is accepted on any rising edge where o_tx_ready && i_tx_byte_valid.
  - i_tx_byte is captured into the shift register at acceptance.
  - Later changes to i_tx_byte have no effect on the frame.
  - i_tx_byte_valid is ignored while o_tx_ready = 0; there is no queueing.
- Acceptance edge: o_tx_ready falls to 0, o_tx_busy rises to 1, and o_tx goes low (start bit), all registered at that edge. Start-bit latency is 1 clock from the accept cycle.
- FSM states and transitions:
  - IDLE: o_tx = 1, ready = 1. Go to START on accept.
  - START: o_tx = 0 for BIT_CLKS clocks.
  - DATA: NUM_DATA_BITS bit periods, shift register LSB first, bit index 0 to NUM_DATA_BITS-1.
  - PARITY: present only if PARITY_ON. Even parity: bit = ^data. Odd parity: bit = ~^data. Parity is computed from the captured word, never from the live input.
  - STOP: o_tx = 1 for NUM_STOP_BITS * BIT_CLKS clocks.
  - Return to IDLE: o_tx_busy falls and o_tx_ready rises together.
- Bit timer: counts 0 to BIT_CLKS-1 and wraps on each bit boundary. The state or bit index advances only on the wrap.
- Frame length: (1 + NUM_DATA_BITS + PARITY_ON + NUM_STOP_BITS) * BIT_CLKS clocks. With defaults this is 11 * 32 = 352 clocks.
- Minimum accept-to-accept spacing is frame length + 1 clock (one IDLE cycle).
- Reset mid-frame: at the next edge o_tx = 1, busy = 0, ready = 0, and the frame is aborted. No partial frame resumes.
- An illegal state encoding recovers to IDLE with reset values.
- Elaboration-time error (generate/$error) if NUM_DATA_BITS is outside 5 to 9, NUM_STOP_BITS is outside 1 to 2, or BIT_CLKS < 2.

Decomposition:
- Shared package uart_pkg contains:
  - localparams EVEN_PAR = 0 and ODD_PAR = 1;
  - function bit_clks(clk, baud, os) implementing the BIT_CLKS formula, reused by uart_rx;
  - typedef uart_tx_state_t {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP}.
- Optional sub-module uart_baud_tick: bit-period counter with a clear input and a one-cycle tick output, BIT_CLKS parameter. It is instantiated once inside uart_tx.

Test Plan:
1. Defaults, send 0x55 (odd parity). o_tx over 352 clocks, one value per 32-clock bit: 0, then 1,0,1,0,1,0,1,0, then parity 1, then stop 1. Sample each bit at its mid-point. busy is high for exactly 352 clocks.
2. PARITY_EO = 0, send 0xA7 (five ones). Data bits LSB first: 1,1,1,0,0,1,0,1. Parity bit = 1.
3. Hold valid high continuously with 0x01 then 0x02. Accepts are exactly 353 clocks apart. No glitch on o_tx between frames. Valid pulses while busy are dropped.
4. Assert i_rst for 1 clock, 100 clocks into a frame of 0x00. Next edge: o_tx = 1, busy = 0, ready = 0. Ready returns 1 clock after release. A new 0x3C frame transmits correctly.
5. Loopback o_tx into uart_rx (same parameters, reset inverted for its active-low input), send 0x3C then 0xFF. uart_rx reports o_rx_byte = 0x3C then 0xFF, o_rx_byte_valid pulses twice, o_rx_err = 0.
6. PARITY_ON = 0, NUM_STOP_BITS = 2, NUM_DATA_BITS = 7, send 0x7F. Frame is 10 bit periods = 320 clocks. No parity bit. o_tx is high for the last 64 clocks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity selectors, transmitter
// state encoding and the bit-period formula shared with uart_rx.
package uart_pkg;

  localparam int EVEN_PAR = 0;
  localparam int ODD_PAR  = 1;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } uart_tx_state_t;

  // Integer division first, so tx and rx land on the same
  // whole number of clocks per bit.
  function automatic int bit_clks(
    input int clk,
    input int baud,
    input int os
  );
    return os * (clk / (baud * os));
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..BIT_CLKS-1 and wraps.
// Ports: clk, rst (sync, high), clr (hold at 0), tick (wrap cycle).
module uart_baud_tick #(
  parameter int BIT_CLKS = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W =
    (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;
  localparam logic [W-1:0] LAST = W'(BIT_CLKS - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional parity, stop.
// Ports: i_clk, i_rst (sync, high), i_tx_byte/i_tx_byte_valid in;
// o_tx_ready, o_tx (idle high), o_tx_busy out; all registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_MHZ    = 100_000_000,
  parameter int BAUD_RATE       = 3_000_000,
  parameter int OVERSAMPLE_RATE = 16,
  parameter int NUM_DATA_BITS   = 8,
  parameter int PARITY_ON       = 1,
  parameter int PARITY_EO       = 1,
  parameter int NUM_STOP_BITS   = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_DATA_BITS-1:0] i_tx_byte,
  input  logic                     i_tx_byte_valid,
  output logic                     o_tx_ready,
  output logic                     o_tx,
  output logic                     o_tx_busy
);

  localparam int BIT_CLKS =
    bit_clks(CLK_FREQ_MHZ, BAUD_RATE, OVERSAMPLE_RATE);

  localparam logic [2:0] IDLE   = TX_IDLE;
  localparam logic [2:0] START  = TX_START;
  localparam logic [2:0] DATA   = TX_DATA;
  localparam logic [2:0] PARITY = TX_PARITY;
  localparam logic [2:0] STOP   = TX_STOP;

  localparam logic [3:0] DATA_LAST = 4'(NUM_DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(NUM_STOP_BITS - 1);

  generate
    if (NUM_DATA_BITS < 5 || NUM_DATA_BITS > 9) begin : g_bad_nb
      $error("uart_tx: NUM_DATA_BITS must be 5..9");
    end
    if (NUM_STOP_BITS < 1 || NUM_STOP_BITS > 2) begin : g_bad_ns
      $error("uart_tx: NUM_STOP_BITS must be 1..2");
    end
    if (BIT_CLKS < 2) begin : g_bad_bc
      $error("uart_tx: BIT_CLKS must be at least 2");
    end
  endgenerate

  logic [2:0]               state;
  logic [NUM_DATA_BITS-1:0] shreg;
  logic                     par;
  logic [3:0]               idx;
  logic                     tick;
  logic                     clr;

  // Timer is held at zero while idle so every frame starts
  // a full bit period from the accept edge.
  assign clr = (state == IDLE);

  uart_baud_tick #(
    .BIT_CLKS(BIT_CLKS)
  ) u_tick (
    .clk (i_clk),
    .rst (i_rst),
    .clr (clr),
    .tick(tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      o_tx       <= 1'b1;
      o_tx_ready <= 1'b0;
      o_tx_busy  <= 1'b0;
      shreg      <= '0;
      par        <= 1'b0;
      idx        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (o_tx_ready && i_tx_byte_valid) begin
            state      <= START;
            shreg      <= i_tx_byte;
            par        <= (PARITY_EO == ODD_PAR) ?
                          ~^i_tx_byte : ^i_tx_byte;
            o_tx       <= 1'b0;
            o_tx_ready <= 1'b0;
            o_tx_busy  <= 1'b1;
            idx        <= '0;
          end else begin
            o_tx       <= 1'b1;
            o_tx_ready <= 1'b1;
            o_tx_busy  <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            o_tx  <= shreg[0];
            shreg <= shreg >> 1;
            idx   <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            if (idx == DATA_LAST) begin
              idx <= '0;
              if (PARITY_ON != 0) begin
                state <= PARITY;
                o_tx  <= par;
              end else begin
                state <= STOP;
                o_tx  <= 1'b1;
              end
            end else begin
              idx   <= idx + 1'b1;
              o_tx  <= shreg[0];
              shreg <= shreg >> 1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state <= STOP;
            o_tx  <= 1'b1;
            idx   <= '0;
          end
        end
        STOP: begin
          if (tick) begin
            if (idx == STOP_LAST) begin
              state      <= IDLE;
              o_tx_busy  <= 1'b0;
              o_tx_ready <= 1'b1;
              idx        <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          o_tx       <= 1'b1;
          o_tx_ready <= 1'b0;
          o_tx_busy  <= 1'b0;
          shreg      <= '0;
          par        <= 1'b0;
          idx        <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: three configurations checked cycle by
// cycle against a frame model built from the frame rules.
module tb_uart_tx;

  localparam int BITC = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] din   [3];
  logic       valid [3];
  logic       ready [3];
  logic       tx    [3];
  logic       busy  [3];

  int nb   [3] = '{8, 8, 7};
  int pon  [3] = '{1, 1, 0};
  int podd [3] = '{1, 0, 1};
  int nst  [3] = '{1, 1, 2};

  int     vectors = 0;
  int     errors  = 0;
  longint cyc     = 0;
  int     exp_q[$];

  always @(posedge clk) cyc++;

  uart_tx #(.PARITY_EO(1)) u0 (
    .i_clk(clk), .i_rst(rst),
    .i_tx_byte(din[0]), .i_tx_byte_valid(valid[0]),
    .o_tx_ready(ready[0]), .o_tx(tx[0]), .o_tx_busy(busy[0])
  );

  uart_tx #(.PARITY_EO(0)) u1 (
    .i_clk(clk), .i_rst(rst),
    .i_tx_byte(din[1]), .i_tx_byte_valid(valid[1]),
    .o_tx_ready(ready[1]), .o_tx(tx[1]), .o_tx_busy(busy[1])
  );

  uart_tx #(
    .NUM_DATA_BITS(7), .PARITY_ON(0), .NUM_STOP_BITS(2)
  ) u2 (
    .i_clk(clk), .i_rst(rst),
    .i_tx_byte(din[2][6:0]), .i_tx_byte_valid(valid[2]),
    .o_tx_ready(ready[2]), .o_tx(tx[2]), .o_tx_busy(busy[2])
  );

  // Expected line level for each bit period of one frame.
  function automatic void build(input int k, input int w);
    int ones;
    int b;
    ones = 0;
    exp_q.delete();
    exp_q.push_back(0);
    for (int i = 0; i < nb[k]; i++) begin
      b = (w >> i) & 1;
      ones += b;
      exp_q.push_back(b);
    end
    if (pon[k] != 0)
      exp_q.push_back(podd[k] != 0 ? 1 - (ones % 2) : ones % 2);
    for (int s = 0; s < nst[k]; s++) exp_q.push_back(1);
  endfunction

  task automatic wait_ready(input int k);
    bit seen;
    seen = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (ready[k] === 1'b1) seen = 1;
    end
    vectors++;
    if (!seen) begin
      errors++;
      $display("FAIL ready_timeout u%0d: ready=%b, need 1",
               k, ready[k]);
    end
  endtask

  // Entered at a negedge with valid high and ready seen high.
  task automatic run_frame(input int k, input int w,
                           input bit hold, output longint acc);
    int len;
    build(k, w);
    len = exp_q.size() * BITC;
    acc = 0;
    @(posedge clk);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (c == 0) begin
        acc = cyc;
        din[k] = 8'($urandom);
        if (!hold) valid[k] = 1'b0;
      end
      vectors++;
      if (tx[k] !== 1'(exp_q[c / BITC]) ||
          busy[k] !== 1'b1 || ready[k] !== 1'b0) begin
        errors++;
        if (errors < 30)
          $display({"FAIL frame u%0d w=%h clk %0d: tx=%b busy=%b",
                    " ready=%b, need tx=%0d busy=1 ready=0"},
                   k, w, c, tx[k], busy[k], ready[k],
                   exp_q[c / BITC]);
      end
    end
    @(negedge clk);
    vectors++;
    if (busy[k] !== 1'b0 || ready[k] !== 1'b1 || tx[k] !== 1'b1) begin
      errors++;
      $display("FAIL frame_end u%0d: busy=%b ready=%b tx=%b, need 0 1 1",
               k, busy[k], ready[k], tx[k]);
    end
  endtask

  task automatic send(input int k, input int w);
    longint a;
    din[k] = 8'(w);
    valid[k] = 1'b1;
    wait_ready(k);
    run_frame(k, w, 1'b0, a);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      valid[k] = 1'b0;
      din[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (tx[k] !== 1'b1 || ready[k] !== 1'b0 || busy[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset u%0d: tx=%b ready=%b busy=%b, need 1 0 0",
                 k, tx[k], ready[k], busy[k]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (ready[k] !== 1'b1 || tx[k] !== 1'b1) begin
        errors++;
        $display("FAIL ready_rise u%0d: ready=%b tx=%b, need 1 1",
                 k, ready[k], tx[k]);
      end
    end
  endtask

  task automatic test_parity;
    send(0, 8'h55);
    send(1, 8'hA7);
    send(2, 8'h7F);
  endtask

  task automatic test_back_to_back;
    longint a1;
    longint a2;
    din[0] = 8'h01;
    valid[0] = 1'b1;
    wait_ready(0);
    run_frame(0, 8'h01, 1'b1, a1);
    din[0] = 8'h02;
    run_frame(0, 8'h02, 1'b0, a2);
    vectors++;
    if (a2 - a1 != 353) begin
      errors++;
      $display("FAIL accept_spacing: got %0d clocks, need 353",
               a2 - a1);
    end
  endtask

  task automatic test_reset_abort;
    din[0] = 8'h00;
    valid[0] = 1'b1;
    wait_ready(0);
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort u0: tx=%b busy=%b ready=%b, need 1 0 0",
               tx[0], busy[0], ready[0]);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (ready[0] !== 1'b1 || busy[0] !== 1'b0 || tx[0] !== 1'b1) begin
      errors++;
      $display("FAIL abort_release u0: ready=%b busy=%b tx=%b, need 1 0 1",
               ready[0], busy[0], tx[0]);
    end
    send(0, 8'h3C);
  endtask

  task automatic test_random;
    int k;
    int w;
    for (int n = 0; n < 6; n++) begin
      k = int'($urandom_range(0, 2));
      w = int'($urandom & ((k == 2) ? 32'h7F : 32'hFF));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send(k, w);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      valid[k] = 1'b0;
      din[k] = '0;
    end
    test_reset();
    test_parity();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
